// File: rtl/wr_ctrl.sv
// Host write controller: assembles a 512-bit message block from
// addressed 32-bit writes and hands it to the hash core.
module wr_ctrl #(
  parameter int DW = 32,
  parameter int NW = 16,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_d,
  input  logic             start,
  input  logic             blk_rdy,
  input  logic             hash_done,
  output logic [NW*DW-1:0] msg_blk,
  output logic             blk_vld,
  output logic             busy,
  output logic             done,
  output logic             wr_err,
  output logic             start_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HASH
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [NW-1:0]    wr_mask;
  logic [NW-1:0]    mask_n;
  logic [NW-1:0]    wr_bit;
  logic [NW*DW-1:0] msg_n;
  logic             vld_n;
  logic             busy_n;
  logic             done_n;
  logic             werr_n;
  logic             serr_n;

  always_comb begin
    state_n = state;
    msg_n   = msg_blk;
    mask_n  = wr_mask;
    vld_n   = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    werr_n  = 1'b0;
    serr_n  = 1'b0;
    wr_bit  = {{(NW-1){1'b0}}, wr_en} << wr_addr;
    unique case (state)
      IDLE: begin
        // A write in the start cycle counts toward completeness.
        if (wr_en) begin
          msg_n[(NW-1-int'(wr_addr))*DW +: DW] = wr_d;
          mask_n = wr_mask | wr_bit;
        end
        if (start) begin
          if (&mask_n) begin
            state_n = LOAD;
            vld_n   = 1'b1;
            busy_n  = 1'b1;
          end else begin
            serr_n = 1'b1;
          end
        end
      end
      LOAD: begin
        busy_n = 1'b1;
        werr_n = wr_en;
        serr_n = start;
        if (blk_rdy) begin
          state_n = HASH;
        end else begin
          vld_n = 1'b1;
        end
      end
      HASH: begin
        werr_n = wr_en;
        serr_n = start;
        if (hash_done) begin
          state_n = IDLE;
          done_n  = 1'b1;
          mask_n  = '0;
        end else begin
          busy_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      msg_blk   <= '0;
      wr_mask   <= '0;
      blk_vld   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state     <= state_n;
      msg_blk   <= msg_n;
      wr_mask   <= mask_n;
      blk_vld   <= vld_n;
      busy      <= busy_n;
      done      <= done_n;
      wr_err    <= werr_n;
      start_err <= serr_n;
    end
  end

endmodule

// File: tb/tb_wr_ctrl.sv
// Table-driven bench for wr_ctrl; expectations flow through a
// one-cycle scoreboard queue.
module tb_wr_ctrl;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_d;
  logic         start;
  logic         blk_rdy;
  logic         hash_done;
  logic [511:0] msg_blk;
  logic         blk_vld;
  logic         busy;
  logic         done;
  logic         wr_err;
  logic         start_err;

  wr_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_d      (wr_d),
    .start     (start),
    .blk_rdy   (blk_rdy),
    .hash_done (hash_done),
    .msg_blk   (msg_blk),
    .blk_vld   (blk_vld),
    .busy      (busy),
    .done      (done),
    .wr_err    (wr_err),
    .start_err (start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp flags: {blk_vld, busy, done, wr_err, start_err}
  typedef struct {
    logic        r;
    logic        we;
    logic [3:0]  a;
    logic [31:0] d;
    logic        st;
    logic        rdy;
    logic        hd;
    logic [4:0]  exp;
    logic        chk;
    logic [31:0] hi;
    logic [31:0] w3;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    int          idx;
    logic [4:0]  exp;
    logic        chk;
    logic [31:0] hi;
    logic [31:0] w3;
    logic [31:0] lo;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   passed;
  int   total;

  function automatic void add(
    input logic r, input logic we, input logic [3:0] a,
    input logic [31:0] d, input logic st, input logic rdy,
    input logic hd, input logic [4:0] e, input logic c,
    input logic [31:0] hi, input logic [31:0] w3,
    input logic [31:0] lo);
    vec_t t;
    t.r = r; t.we = we; t.a = a; t.d = d;
    t.st = st; t.rdy = rdy; t.hd = hd; t.exp = e;
    t.chk = c; t.hi = hi; t.w3 = w3; t.lo = lo;
    vecs.push_back(t);
  endfunction

  function automatic void idle(input logic [4:0] e);
    add(0, 0, 0, 0, 0, 0, 0, e, 0, 0, 0, 0);
  endfunction

  function automatic void wr(input logic [3:0] a,
                             input logic [31:0] d,
                             input logic [4:0] e);
    add(0, 1, a, d, 0, 0, 0, e, 0, 0, 0, 0);
  endfunction

  initial begin
    exp_t        e;
    logic [4:0]  got;
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_d      = '0;
    start     = 1'b0;
    blk_rdy   = 1'b0;
    hash_done = 1'b0;

    // reset state
    add(1, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 0, 0);
    // 1: full block, start, accept on first LOAD cycle
    for (int i = 0; i < 16; i++) wr(4'(i), 32'(i), 5'b00000);
    add(0, 0, 0, 0, 1, 0, 0, 5'b11000, 1, 32'h0, 32'h3, 32'hF);
    add(0, 0, 0, 0, 0, 1, 0, 5'b01000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 5'b00100, 0, 0, 0, 0);
    idle(5'b00000);
    // 2: addr 7 missing -> start_err, then fill and start
    for (int i = 0; i < 16; i++)
      if (i != 7) wr(4'(i), 32'h100 + 32'(i), 5'b00000);
    add(0, 0, 0, 0, 1, 0, 0, 5'b00001, 0, 0, 0, 0);
    idle(5'b00000);
    wr(7, 32'h107, 5'b00000);
    add(0, 0, 0, 0, 1, 0, 0, 5'b11000, 1, 32'h100, 32'h103, 32'h10F);
    // 3: core stalls, block must hold
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 0, 0, 5'b11000, 1, 32'h100, 32'h103, 32'h10F);
    add(0, 0, 0, 0, 0, 1, 0, 5'b01000, 0, 0, 0, 0);
    // 4: write and start dropped in HASH, then completion
    add(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 5'b01010, 1, 32'h100, 32'h103, 32'h10F);
    add(0, 0, 0, 0, 1, 0, 0, 5'b01001, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 5'b00100, 1, 32'h100, 32'h103, 32'h10F);
    add(0, 0, 0, 0, 1, 0, 0, 5'b00001, 1, 32'h100, 32'h103, 32'h10F);
    // 5: last word written with start; overwrite of addr 3
    wr(3, 32'hAAAA, 5'b00000);
    for (int i = 0; i < 15; i++) wr(4'(i), 32'h200 + 32'(i), 5'b00000);
    add(0, 1, 15, 32'hCAFE0015, 1, 0, 0, 5'b11000, 1, 32'h200, 32'h203, 32'hCAFE0015);
    add(0, 0, 0, 0, 0, 0, 1, 5'b11000, 0, 0, 0, 0);
    add(0, 1, 5, 32'h5555, 0, 0, 0, 5'b11010, 1, 32'h200, 32'h203, 32'hCAFE0015);
    // 6: reset in LOAD, stray hash_done, mask gone
    add(1, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 5'b00001, 1, 0, 0, 0);
    idle(5'b00000);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t x;
      rst       = vecs[i].r;
      wr_en     = vecs[i].we;
      wr_addr   = vecs[i].a;
      wr_d      = vecs[i].d;
      start     = vecs[i].st;
      blk_rdy   = vecs[i].rdy;
      hash_done = vecs[i].hd;
      x.idx = i; x.exp = vecs[i].exp; x.chk = vecs[i].chk;
      x.hi = vecs[i].hi; x.w3 = vecs[i].w3; x.lo = vecs[i].lo;
      sb.push_back(x);
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      got = {blk_vld, busy, done, wr_err, start_err};
      total++;
      if (got === e.exp) passed++;
      else $display("FAIL flags vec %0d: got %b want %b", e.idx, got, e.exp);
      if (e.chk) begin
        total++;
        if (msg_blk[511:480] === e.hi && msg_blk[415:384] === e.w3 &&
            msg_blk[31:0] === e.lo)
          passed++;
        else
          $display("FAIL msg_blk vec %0d: got %h/%h/%h want %h/%h/%h",
                   e.idx, msg_blk[511:480], msg_blk[415:384],
                   msg_blk[31:0], e.hi, e.w3, e.lo);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
